// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring radix-2 integer divider for the execute stage.
//
// A divide (DIV or DIVU) is accepted in IDLE on a start pulse. It takes one
// iteration per result bit and then reports quotient (LO) and remainder (HI)
// with a one-cycle done pulse. While the divide is in flight, stall holds the
// younger pipeline stages.
//
// Optional feature macro: DIV_SIGNED_EN
//   defined   -> is_signed selects DIV; sign-magnitude conversion and
//                result negation are built in.
//   undefined -> every divide is unsigned; the negation logic is absent.
//
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset (aborts any divide)
//   start      in   divide request, honoured only in IDLE
//   is_signed  in   1 = DIV, 0 = DIVU (sampled with start)
//   dividend   in   WIDTH-bit rs operand (sampled with start)
//   divisor    in   WIDTH-bit rt operand (sampled with start)
//   stall      out  start in IDLE, or a divide iterating
//   done       out  one-cycle pulse; quo/rem valid
//   quo        out  WIDTH-bit quotient (LO)
//   rem        out  WIDTH-bit remainder (HI)
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] acc_q;   // partial remainder
    logic [WIDTH-1:0] qw_q;    // dividend bits shifting out / quotient bits shifting in
    logic [WIDTH-1:0] dvs_q;   // divisor magnitude
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rem_q;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] qw_d;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

`ifdef DIV_SIGNED_EN
    logic qneg_q;
    logic rneg_q;
    logic op_signed;
    logic qneg_d;
    logic rneg_d;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    assign op_signed = is_signed;
    // The most negative value maps onto itself, which is still the correct
    // unsigned magnitude, so -2^(W-1) / -1 needs no special case.
    assign a_mag   = (op_signed && dividend[WIDTH-1]) ? negate(dividend) : dividend;
    assign b_mag   = (op_signed && divisor[WIDTH-1])  ? negate(divisor)  : divisor;
    assign qneg_d  = op_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
    assign rneg_d  = op_signed & dividend[WIDTH-1];
    assign quo_fix = qneg_q ? negate(qw_d)  : qw_d;
    assign rem_fix = rneg_q ? negate(acc_d) : acc_d;
`else
    logic unused_is_signed;

    assign unused_is_signed = is_signed;
    assign a_mag   = dividend;
    assign b_mag   = divisor;
    assign quo_fix = qw_d;
    assign rem_fix = acc_d;
`endif

    // One restoring step: shift {acc, qw} left, trial-subtract the divisor
    // with one extra bit so the borrow shows up as the sign of the result.
    always_comb begin
        shifted = {acc_q, qw_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
        acc_d   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        qw_d    = {qw_q[WIDTH-2:0], ~trial[WIDTH]};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            qw_q    <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
`ifdef DIV_SIGNED_EN
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q  <= '0;
                        cnt_q  <= '0;
                        qw_q   <= a_mag;
                        dvs_q  <= b_mag;
`ifdef DIV_SIGNED_EN
                        qneg_q <= qneg_d;
                        rneg_q <= rneg_d;
`endif
                        if (divisor == '0) begin
                            // Divide by zero: raw dividend, no sign fix-up.
                            quo_q   <= '1;
                            rem_q   <= dividend;
                            state_q <= FIN;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    qw_q  <= qw_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        quo_q   <= quo_fix;
                        rem_q   <= rem_fix;
                        state_q <= FIN;
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign stall = ((state_q == IDLE) && start) || (state_q == RUN);
    assign done  = (state_q == FIN);
    assign quo   = quo_q;
    assign rem   = rem_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed bench for div_unit, checked against a
// plain-arithmetic reference model of integer division.
module tb_div_unit;
    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset_n;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         stall;
    logic         done;
    logic [W-1:0] quo;
    logic [W-1:0] rem;

    int n_checks = 0;
    int n_fail   = 0;

    div_unit #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .stall     (stall),
        .done      (done),
        .quo       (quo),
        .rem       (rem)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: truncating division, remainder takes the dividend's sign,
    // x/0 gives all-ones and the raw dividend.
    function automatic void ref_div(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] q, output logic [W-1:0] r);
        bit     s;
        longint sa;
        longint sb;
        s = sgn;
`ifndef DIV_SIGNED_EN
        s = 1'b0;
`endif
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic do_div(input string tag, input bit sgn, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int inject_at);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        int           lat;
        int           stalls;
        bit           seen;
        ref_div(sgn, a, b, eq, er);
        @(negedge clock);
        start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
        #1;
        check_eq({tag, " stall_start"}, W'(stall), 1);
        lat = 0; stalls = 0; seen = 1'b0;
        while (lat < 100 && !seen) begin
            @(negedge clock);
            start = 1'b0;
            lat++;
            if (lat == inject_at) begin
                start = 1'b1; is_signed = 1'b0; dividend = 1; divisor = 1;
            end
            if (done) seen = 1'b1;
            else if (stall) stalls++;
        end
        check_eq({tag, " done_seen"}, W'(seen), 1);
        check_eq({tag, " latency"}, W'(lat), (b == 0) ? 1 : 33);
        check_eq({tag, " stall_cycles"}, W'(stalls), (b == 0) ? 0 : 32);
        check_eq({tag, " stall_at_done"}, W'(stall), 0);
        check_eq({tag, " quo"}, quo, eq);
        check_eq({tag, " rem"}, rem, er);
        @(negedge clock);
        start = 1'b0;
        check_eq({tag, " single_done"}, W'(done), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n_done;
        logic [W-1:0] a;
        logic [W-1:0] b;
        bit sg;
        reset_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (2) @(negedge clock);
        check_eq("rst quo", quo, 0);
        check_eq("rst rem", rem, 0);
        check_eq("rst done", W'(done), 0);
        check_eq("rst stall", W'(stall), 0);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_eq("idle no_done", W'(done), 0);
        end

        do_div("divu_100_7", 1'b0, 100, 7, -1);
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 2, -1);
        do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
        do_div("divu_by0", 1'b0, 32'h1234, 0, -1);
        do_div("divu_ign", 1'b0, 32'hFFFF_FFFF, 16, 10);
        do_div("div_by0_s", 1'b1, 32'hFFFF_FF00, 0, -1);

        // Abort mid-divide with reset.
        @(negedge clock);
        start = 1'b1; is_signed = 1'b0; dividend = 50; divisor = 5;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_eq("abort quo", quo, 0);
        check_eq("abort rem", rem, 0);
        check_eq("abort done", W'(done), 0);
        check_eq("abort stall", W'(stall), 0);
        @(negedge clock);
        reset_n = 1'b1;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) n_done++;
        end
        check_eq("abort no_done", W'(n_done), 0);
        do_div("divu_9_3", 1'b0, 9, 3, -1);

        for (int i = 0; i < 40; i++) begin
            sg = 1'(($urandom_range(0, 1)));
            case ($urandom_range(0, 9))
                0: begin a = $urandom; b = '0; end
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom; b = W'($urandom_range(1, 20)); end
                3: begin a = W'($urandom_range(0, 5)); b = $urandom; end
                default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
            endcase
            do_div("rand", sg, a, b, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
